// File: rtl/rd_req_arbiter.sv
// rd_req_arbiter
//   Round-robin arbiter sharing one AXI read-address channel between N_REQ
//   read requesters (requester i issues with AXI id i). Each requester has a
//   credit counter limiting its outstanding bursts to MAX_OUT; credit is
//   reserved at accept and returned on the last R beat of a burst. R-channel
//   sideband is demultiplexed back to requesters by rid_m; data bypasses.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/addr/len       per-requester request (addr 64b, len 8b, packed)
//   req_ready                per-requester accept (combinational, one-hot)
//   ar*_m                    AXI AR master (arsize fixed at 64 B beats)
//   rid_m/rlast_m/rvalid_m   AXI R sideband in, rready_m out
//   r_valid / r_ready        per-requester R beat handshake
//   outstanding              live credit counters, 4 bits per requester
//   idle                     no burst being issued and all counters zero
module rd_req_arbiter #(
   parameter int N_REQ   = 2,
   parameter int MAX_OUT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*64-1:0] req_addr,
   input  logic [N_REQ*8-1:0]  req_len,
   output logic [N_REQ-1:0]    req_ready,
   output logic [15:0]         arid_m,
   output logic [63:0]         araddr_m,
   output logic [7:0]          arlen_m,
   output logic [2:0]          arsize_m,
   output logic                arvalid_m,
   input  logic                arready_m,
   input  logic [15:0]         rid_m,
   input  logic                rlast_m,
   input  logic                rvalid_m,
   output logic                rready_m,
   output logic [N_REQ-1:0]    r_valid,
   input  logic [N_REQ-1:0]    r_ready,
   output logic [N_REQ*4-1:0]  outstanding,
   output logic                idle
);

   localparam int unsigned N_U       = N_REQ;
   localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0]  MAX_OUT_C = 4'(MAX_OUT);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [15:0]      arid_q, arid_d;
   logic [63:0]      araddr_q, araddr_d;
   logic [7:0]       arlen_q, arlen_d;
   logic [3:0]       out_q [N_REQ];
   logic [3:0]       out_d [N_REQ];
   logic             idle_q, idle_d;

   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] retire;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             accept;
   int unsigned      cand;

   // Eligibility: pending request and a free credit.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         eligible[i] = req_valid[i] && (out_q[i] < MAX_OUT_C);
      end
   end

   // Round-robin scan starting one past the last granted requester.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int unsigned k = 1; k <= N_U; k++) begin
         cand = (32'(last_grant_q) + k) % N_U;
         for (int unsigned i = 0; i < N_U; i++) begin
            if (!grant_valid && (cand == i) && eligible[i]) begin
               grant_valid = 1'b1;
               grant_idx   = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         req_ready[i] = !rst && (state_q == IDLE) && grant_valid &&
                        (grant_idx == IDX_W'(i));
      end
   end

   assign accept = |req_ready;

   // AR request FSM; AR fields are captured at accept and held through ISSUE.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d      = ISSUE;
               last_grant_d = grant_idx;
               arid_d       = 16'(grant_idx);
               for (int unsigned i = 0; i < N_U; i++) begin
                  if (req_ready[i]) begin
                     araddr_d = {req_addr[64*i+6 +: 58], 6'b0};
                     arlen_d  = req_len[8*i +: 8];
                  end
               end
            end
         end
         ISSUE: begin
            if (arready_m) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // R demux; ids outside the requester range are drained (rready_m = 1).
   always_comb begin
      rready_m = 1'b1;
      r_valid  = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         if (rid_m == 16'(i)) begin
            r_valid[i] = rvalid_m;
            rready_m   = r_ready[i];
         end
      end
   end

   always_comb begin
      retire = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         retire[i] = r_valid[i] && rready_m && rlast_m;
      end
   end

   // Credit counters: accept and retire in the same cycle cancel; a retire
   // at zero (stale beat after reset) saturates.
   always_comb begin
      for (int unsigned i = 0; i < N_U; i++) begin
         out_d[i] = out_q[i];
         if (req_ready[i] && !retire[i]) begin
            out_d[i] = out_q[i] + 4'd1;
         end else if (!req_ready[i] && retire[i] && (out_q[i] != '0)) begin
            out_d[i] = out_q[i] - 4'd1;
         end
      end
   end

   always_comb begin
      idle_d = (state_d == IDLE);
      for (int unsigned i = 0; i < N_U; i++) begin
         if (out_d[i] != '0) begin
            idle_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDX_W'(N_REQ - 1);
         arid_q       <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         idle_q       <= 1'b1;
         for (int unsigned i = 0; i < N_U; i++) begin
            out_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         arid_q       <= arid_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         idle_q       <= idle_d;
         for (int unsigned i = 0; i < N_U; i++) begin
            out_q[i] <= out_d[i];
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         outstanding[4*i +: 4] = out_q[i];
      end
   end

   assign arvalid_m = (state_q == ISSUE);
   assign arid_m    = arid_q;
   assign araddr_m  = araddr_q;
   assign arlen_m   = arlen_q;
   assign arsize_m  = 3'b110;
   assign idle      = idle_q;

endmodule
